// File: rtl/dma_seq.sv
// Two-dimensional DMA address sequencer: walks x/y counters over a strided
// region and drives a ready-handshaked memory port, with optional read-modify-write.
module dma_seq #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PAGE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              rmw,
  input  logic              xskip,
  input  logic              yskip,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  x_len,
  input  logic [CNT_W-1:0]  y_len,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              wr_en,
  output logic              page_cross,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PG_HI = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_ADV, S_PAGE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [CNT_W-1:0]   xcnt_q, xcnt_d;
  logic [CNT_W-1:0]   ycnt_q, ycnt_d;
  logic [CNT_W-1:0]   x_len_q, x_len_d;
  logic [CNT_W-1:0]   y_len_q, y_len_d;
  logic               rmw_q, rmw_d;
  logic               xskip_q, xskip_d;
  logic               yskip_q, yskip_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic               page_cross_q, page_cross_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               x_more, y_more;
  logic [ADDR_W-1:0]  row_step;
  logic [ADDR_W:0]    x_sum, y_sum;

  // Address arithmetic carries an extra bit so a wrap through zero is visible.
  always_comb begin
    x_more   = xcnt_q < CNT_W'(x_len_q - CNT_W'(1));
    y_more   = ycnt_q < CNT_W'(y_len_q - CNT_W'(1));
    row_step = yskip_q ? ADDR_W'(stride_q << 1) : stride_q;
    x_sum    = {1'b0, addr_q} + (ADDR_W + 1)'(xskip_q ? 2 : 1);
    y_sum    = {1'b0, row_base_q} + {1'b0, row_step};
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      x_len_q      <= '0;
      y_len_q      <= '0;
      rmw_q        <= 1'b0;
      xskip_q      <= 1'b0;
      yskip_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      page_cross_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      stride_q     <= stride_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      x_len_q      <= x_len_d;
      y_len_q      <= y_len_d;
      rmw_q        <= rmw_d;
      xskip_q      <= xskip_d;
      yskip_q      <= yskip_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      page_cross_q <= page_cross_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state and next datapath values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    xcnt_d     = xcnt_q;
    ycnt_d     = ycnt_q;
    x_len_d    = x_len_q;
    y_len_d    = y_len_q;
    rmw_d      = rmw_q;
    xskip_d    = xskip_q;
    yskip_d    = yskip_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_d     = base_addr;
          row_base_d = base_addr;
          stride_d   = stride;
          xcnt_d     = '0;
          ycnt_d     = '0;
          x_len_d    = x_len;
          y_len_d    = y_len;
          rmw_d      = rmw;
          xskip_d    = xskip;
          yskip_d    = yskip;
          state_d    = (x_len == '0 || y_len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (abort)      state_d = S_IDLE;
        else if (ready) state_d = rmw_q ? S_WR : S_ADV;
      end
      S_WR: begin
        if (abort)      state_d = S_IDLE;
        else if (ready) state_d = S_ADV;
      end
      S_ADV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_more) begin
          xcnt_d  = xcnt_q + CNT_W'(1);
          addr_d  = x_sum[ADDR_W-1:0];
          state_d = (x_sum[ADDR_W] ||
                     x_sum[PG_HI:PAGE_W] != addr_q[PG_HI:PAGE_W]) ? S_PAGE : S_RD;
        end else if (y_more) begin
          ycnt_d     = ycnt_q + CNT_W'(1);
          xcnt_d     = '0;
          row_base_d = y_sum[ADDR_W-1:0];
          addr_d     = y_sum[ADDR_W-1:0];
          state_d    = (y_sum[ADDR_W] ||
                        y_sum[PG_HI:PAGE_W] != addr_q[PG_HI:PAGE_W]) ? S_PAGE : S_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PAGE:  state_d = abort ? S_IDLE : S_RD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_comb begin
    rd_en_d      = (state_d == S_RD);
    wr_en_d      = (state_d == S_WR);
    page_cross_d = (state_d == S_PAGE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  assign addr       = addr_q;
  assign rd_en      = rd_en_q;
  assign wr_en      = wr_en_q;
  assign page_cross = page_cross_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dma_seq.sv
// Directed bench for dma_seq: fixed jobs with hand-computed address traces,
// cycle counts and pulse positions.
module tb_dma_seq;

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, rmw, xskip, yskip, ready;
  logic [AW-1:0] base_addr, stride, addr;
  logic [CW-1:0] x_len, y_len;
  logic          rd_en, wr_en, page_cross, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic [AW-1:0] rd_q[$];
  int pc_n, pc_cyc, done_n, done_cyc;
  logic [AW-1:0] pc_addr;

  dma_seq #(.ADDR_W(AW), .CNT_W(CW), .PAGE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rmw(rmw),
    .xskip(xskip), .yskip(yskip), .base_addr(base_addr), .stride(stride),
    .x_len(x_len), .y_len(y_len), .ready(ready), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .page_cross(page_cross), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulses start for one edge; afterwards the bench observes cycle 1.
  task automatic launch();
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  // Runs a job with ready held high, recording reads, page pulses and done.
  task automatic collect(input int budget);
    rd_q.delete();
    pc_n = 0; pc_cyc = -1; pc_addr = '0; done_n = 0; done_cyc = -1;
    while (done_n == 0 && cyc < budget) begin
      if (rd_en) rd_q.push_back(addr);
      if (page_cross) begin pc_n++; pc_cyc = cyc; pc_addr = addr; end
      if (done) begin done_n++; done_cyc = cyc; end
      else step();
    end
    chk("done_seen", 32'(done_n), 32'd1);
    step();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_reads(input string tag, input logic [AW-1:0] e[$]);
    chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i),
          (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD_BEEF, 32'(e[i]));
  endtask

  initial begin
    int rd_cycles, wr_cycles, bad_addr;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rmw = 1'b0; xskip = 1'b0; yskip = 1'b0;
    base_addr = '0; stride = '0; x_len = '0; y_len = '0; ready = 1'b1; cyc = 0;

    // Reset state
    step(); step();
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_page", 32'(page_cross), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    // Job 1: three reads in one row; config scrambled after start
    base_addr = 16'h0010; x_len = 8'd3; y_len = 8'd1;
    launch();
    base_addr = 16'hAAAA; x_len = 8'd9; y_len = 8'd9;
    chk("t1_rd_c1", 32'(rd_en), 32'd1);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    collect(40);
    check_reads("t1", '{16'h0010, 16'h0011, 16'h0012});
    chk("t1_done_cyc", 32'(done_cyc), 32'd7);
    chk("t1_pages", 32'(pc_n), 32'd0);

    // Job 2: row crossing a 256-word page boundary
    base_addr = 16'h00FE; x_len = 8'd4; y_len = 8'd1;
    launch();
    collect(40);
    check_reads("t2", '{16'h00FE, 16'h00FF, 16'h0100, 16'h0101});
    chk("t2_pages", 32'(pc_n), 32'd1);
    chk("t2_page_cyc", 32'(pc_cyc), 32'd5);
    chk("t2_page_addr", 32'(pc_addr), 32'h0100);
    chk("t2_done_cyc", 32'(done_cyc), 32'd10);

    // Job 3: 2x3 with x and y skip
    base_addr = 16'h1000; stride = 16'h0020; x_len = 8'd2; y_len = 8'd3;
    xskip = 1'b1; yskip = 1'b1;
    launch();
    xskip = 1'b0; yskip = 1'b0;
    collect(60);
    check_reads("t3", '{16'h1000, 16'h1002, 16'h1040, 16'h1042, 16'h1080, 16'h1082});
    chk("t3_pages", 32'(pc_n), 32'd0);
    chk("t3_done_cyc", 32'(done_cyc), 32'd13);

    // Job 4: RMW single element, ready accepted on every third cycle
    base_addr = 16'h0234; x_len = 8'd1; y_len = 8'd1; rmw = 1'b1; ready = 1'b0;
    launch();
    rmw = 1'b0;
    rd_cycles = 0; wr_cycles = 0; bad_addr = 0; done_n = 0; done_cyc = -1;
    while (cyc <= 10) begin
      if (rd_en) rd_cycles++;
      if (wr_en) wr_cycles++;
      if ((rd_en || wr_en) && addr !== 16'h0234) bad_addr++;
      if (done) begin done_n++; done_cyc = cyc; end
      ready = (cyc % 3 == 0);
      step();
    end
    ready = 1'b1;
    chk("t4_rd_cycles", 32'(rd_cycles), 32'd3);
    chk("t4_wr_cycles", 32'(wr_cycles), 32'd3);
    chk("t4_addr_stable", 32'(bad_addr), 32'd0);
    chk("t4_done_n", 32'(done_n), 32'd1);
    chk("t4_done_cyc", 32'(done_cyc), 32'd8);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // Job 5: empty job
    base_addr = 16'h0040; x_len = 8'd0; y_len = 8'd5;
    launch();
    chk("t5_busy_c1", 32'(busy), 32'd1);
    chk("t5_done_c1", 32'(done), 32'd1);
    chk("t5_rd_c1", 32'(rd_en), 32'd0);
    step();
    chk("t5_busy_c2", 32'(busy), 32'd0);
    chk("t5_done_c2", 32'(done), 32'd0);
    chk("t5_rd_c2", 32'(rd_en), 32'd0);

    // Simultaneous start and abort in idle stays idle
    x_len = 8'd2; y_len = 8'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_rd", 32'(rd_en), 32'd0);

    // Job 6a: abort during second RD cycle, with ready also high
    base_addr = 16'h0050; x_len = 8'd3; y_len = 8'd1; ready = 1'b0;
    launch();
    chk("t6_rd_c1", 32'(rd_en), 32'd1);
    step();
    chk("t6_rd_c2", 32'(rd_en), 32'd1);
    abort = 1'b1; ready = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_rd", 32'(rd_en), 32'd0);
    chk("t6_abort_done", 32'(done), 32'd0);
    step();
    chk("t6_abort_done2", 32'(done), 32'd0);
    chk("t6_abort_busy2", 32'(busy), 32'd0);

    // Job 6b: wrap from 0xFFFF to 0x0000
    base_addr = 16'hFFFF; x_len = 8'd2; y_len = 8'd1;
    launch();
    collect(40);
    check_reads("t6b", '{16'hFFFF, 16'h0000});
    chk("t6b_pages", 32'(pc_n), 32'd1);
    chk("t6b_page_cyc", 32'(pc_cyc), 32'd3);
    chk("t6b_done_cyc", 32'(done_cyc), 32'd6);

    // Asynchronous reset in the middle of a read
    base_addr = 16'h0300; x_len = 8'd4; y_len = 8'd1;
    launch();
    chk("ar_rd_before", 32'(rd_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_rd_en", 32'(rd_en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_addr", 32'(addr), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("ar_stay_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_seq.md
# dma_seq

Parametrised two-dimensional DMA address sequencer with registered state. It replaces purely combinational next-state/address-control decoding with a self-contained state machine, counters and a memory handshake. It adds configurable widths, row stride, x/y skip, optional read-modify-write and page-crossing detection. It sits between the DMA register file (configuration, `start`) and the memory port (`addr`/`rd_en`/`wr_en`/`ready`).

## Interface
- `ADDR_W`, 16, address width; all address arithmetic is modulo 2^ADDR_W
- `CNT_W`, 8, width of `x_len` and `y_len` and of the internal x/y counters
- `PAGE_W`, 8, page size is 2^PAGE_W words; must satisfy 1 <= PAGE_W < ADDR_W
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; accepted only in IDLE
- `abort`  in  1  forces return to IDLE
- `rmw`  in  1  read-modify-write mode, sampled at start
- `xskip`  in  1  x step of 2 instead of 1, sampled at start
- `yskip`  in  1  row step of 2*stride instead of stride, sampled at start
- `base_addr`  in  ADDR_W  first address
- `stride`  in  ADDR_W  row pitch
- `x_len`  in  CNT_W  elements per row
- `y_len`  in  CNT_W  rows
- `ready`  in  1  memory accepts the current access this cycle
- `addr`  out  ADDR_W  current access address
- `rd_en`  out  1  read request
- `wr_en`  out  1  write request (RMW only)
- `page_cross`  out  1  one-cycle pulse on page change
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RD, WR, ADV, PAGE, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - On `start`, latch all configuration inputs, set row_base = addr = base_addr, and clear xcnt and ycnt.
  - If x_len == 0 or y_len == 0, go to DONE with no accesses. Otherwise go to RD.
- RD: `rd_en` = 1.
  - Hold while `ready` = 0.
  - On `ready`, go to WR if rmw is set, otherwise go to ADV.
- WR: `wr_en` = 1 at the same `addr`. Hold until `ready`, then go to ADV.
- ADV: one cycle, no request. Compute the next address:
  - If xcnt < x_len-1: xcnt += 1 and addr += (xskip ? 2 : 1).
  - Else if ycnt < y_len-1: ycnt += 1, xcnt = 0, row_base += (yskip ? 2*stride : stride), addr = new row_base.
  - Else go to DONE.
  - If the new addr[ADDR_W-1:PAGE_W] differs from the old one, go to PAGE. Otherwise go to RD.
- PAGE: `page_cross` = 1 for one cycle, then go to RD.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `abort` in any non-IDLE state: go to IDLE on the next edge, with no `done` pulse and no further requests. `abort` has priority over `ready`.
- `start` outside IDLE is ignored. Simultaneous `start` and `abort` in IDLE: `abort` wins and the block stays idle.
- Address wrap past 2^ADDR_W-1 to 0 counts as a page change.

## Timing
- Reset values: state IDLE; `addr` = 0; `rd_en`, `wr_en`, `page_cross`, `busy`, `done` = 0; counters = 0.
- `start` sampled at edge 0 gives `rd_en` = 1 and `busy` = 1 in cycle 1.
- With `ready` tied high, cycles per element: 2 (RD, ADV) normally, 3 in RMW mode, plus 1 for each PAGE.
- `done` is asserted one cycle after the final ADV. `busy` falls in the cycle after `done`.
- `addr` is stable throughout RD and WR, including `ready` stalls.
- Configuration inputs may change freely after `start` is accepted.
- Reset mid-transfer clears everything immediately (asynchronously); `rd_en`/`wr_en` drop without waiting for `ready`.

## Test plan
- `base_addr` = 0x0010, `x_len` = 3, `y_len` = 1, `ready` = 1 -> reads at 0x10, 0x11, 0x12; `done` in cycle 7; `page_cross` never asserted.
- `base_addr` = 0x00FE, `x_len` = 4, `y_len` = 1, PAGE_W = 8 -> addresses 0xFE, 0xFF, 0x100, 0x101; one `page_cross` pulse between 0xFF and 0x100.
- `base_addr` = 0x1000, `stride` = 0x20, `x_len` = 2, `y_len` = 3, `xskip` = 1, `yskip` = 1 -> addresses 0x1000, 0x1002, 0x1040, 0x1042, 0x1080, 0x1082.
- `rmw` = 1, `x_len` = 1, `y_len` = 1, `ready` low for 2 cycles in each phase -> `rd_en` then `wr_en` both at `base_addr`, each held for 3 cycles; a single `done`.
- `x_len` = 0 -> `busy` for exactly 1 cycle (DONE), `done` pulse, no `rd_en`.
- `abort` in the 2nd RD cycle, then `start` with `base_addr` = 0xFFFF, `x_len` = 2 -> first job ends with no `done`; second job reads 0xFFFF then 0x0000 with a `page_cross` pulse.
